// File: rtl/flop_div.sv
// Sequential divider for the 13-bit float format {sign, mant[7:0] (m/128), exp[3:0] signed}.
// Restoring mantissa division one quotient bit per clock, then normalise/pack/flag; fixed 10-cycle latency.
module flop_div (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [12:0] one,
  input  logic [12:0] other,
  output logic [12:0] result,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        unf,
  output logic        dz,
  output logic [1:0]  dbg_state_o
);

  // Handshake: start is sampled when the unit can accept (IDLE, or the NORM edge
  // that retires the previous operation); busy is high from the edge after
  // acceptance until done; done is a one-cycle pulse with result/flags valid.
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, NORM = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [7:0]         ma_q, ma_d;
  logic [7:0]         mb_q, mb_d;
  logic signed [5:0]  ediff_q, ediff_d;
  logic [9:0]         rem_q, rem_d;
  logic [8:0]         quo_q, quo_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [12:0]        result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               dz_q, dz_d;

  logic               accept;
  logic               qbit;
  logic [9:0]         rem_sub;
  logic signed [5:0]  exp_n;
  logic [7:0]         mant_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      ma_q     <= 8'd0;
      mb_q     <= 8'd0;
      ediff_q  <= 6'sd0;
      rem_q    <= 10'd0;
      quo_q    <= 9'd0;
      cnt_q    <= 4'd0;
      result_q <= 13'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      ediff_q  <= ediff_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    ediff_d  = ediff_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    busy_d   = (state_q == DIV);
    qbit     = 1'b0;
    rem_sub  = rem_q;
    mant_n   = quo_q[8] ? quo_q[8:1] : quo_q[7:0];
    exp_n    = quo_q[8] ? ediff_q : (ediff_q - 6'sd1);
    accept   = start && ((state_q == IDLE) || (state_q == NORM));

    case (state_q)
      DIV: begin
        if (rem_q >= {2'b00, mb_q}) begin
          qbit    = 1'b1;
          rem_sub = rem_q - {2'b00, mb_q};
        end
        rem_d = {rem_sub[8:0], 1'b0};
        quo_d = {quo_q[7:0], qbit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) state_d = NORM;
      end
      NORM: begin
        done_d = 1'b1;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        dz_d   = 1'b0;
        if (mb_q == 8'd0) begin
          dz_d     = 1'b1;
          result_d = {sign_q, 8'hFF, 4'h7};
        end else if (ma_q == 8'd0) begin
          result_d = 13'h000;
        end else if (exp_n > 6'sd7) begin
          ovf_d    = 1'b1;
          result_d = {sign_q, 8'hFF, 4'h7};
        end else if (exp_n < -6'sd8) begin
          unf_d    = 1'b1;
          result_d = 13'h000;
        end else begin
          result_d = {sign_q, mant_n, exp_n[3:0]};
        end
        state_d = IDLE;
      end
      default: ;
    endcase

    // Loading a new operation on the retiring NORM edge keeps throughput at one per 10 cycles.
    if (accept) begin
      sign_d  = one[12] ^ other[12];
      ma_d    = one[11:4];
      mb_d    = other[11:4];
      ediff_d = $signed({{2{one[3]}}, one[3:0]}) - $signed({{2{other[3]}}, other[3:0]});
      rem_d   = {2'b00, one[11:4]};
      quo_d   = 9'd0;
      cnt_d   = 4'd0;
      state_d = DIV;
    end
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ovf         = ovf_q;
  assign unf         = unf_q;
  assign dz          = dz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_flop_div.sv
// Directed bench for flop_div: latency, packing, flags, handshake and reset abort.
module tb_flop_div;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] one = 13'd0;
  logic [12:0] other = 13'd0;
  logic [12:0] result;
  logic        busy, done, ovf, unf, dz;
  logic [1:0]  dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [12:0] last_res = 13'd0;

  flop_div dut (
    .clk(clk), .reset_n(reset_n), .start(start), .one(one), .other(other),
    .result(result), .busy(busy), .done(done), .ovf(ovf), .unf(unf), .dz(dz),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation accepted at edge 0; checks every cycle through the done edge.
  // With glitch set, stray start pulses with other operands hit edges 3 and 9.
  task automatic do_op(input logic [12:0] a, input logic [12:0] b, input logic [12:0] er,
                       input logic eo, input logic eu, input logic ez, input bit glitch);
    @(negedge clk);
    one = a; other = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_e0", {12'd0, busy}, 13'd0);
    chk("done_e0", {12'd0, done}, 13'd0);
    for (int k = 1; k <= 10; k++) begin
      if (glitch && (k == 3 || k == 9)) begin
        start = 1'b1; one = 13'h0808; other = 13'h0FF7;
      end else begin
        start = 1'b0; one = a; other = b;
      end
      @(posedge clk);
      @(negedge clk);
      if (k < 10) begin
        chk($sformatf("busy_c%0d", k), {12'd0, busy}, 13'd1);
        chk($sformatf("done_c%0d", k), {12'd0, done}, 13'd0);
        chk($sformatf("hold_c%0d", k), result, last_res);
      end else begin
        chk("done_c10", {12'd0, done}, 13'd1);
        chk("busy_c10", {12'd0, busy}, 13'd0);
        chk("result", result, er);
        chk("ovf", {12'd0, ovf}, {12'd0, eo});
        chk("unf", {12'd0, unf}, {12'd0, eu});
        chk("dz", {12'd0, dz}, {12'd0, ez});
        last_res = er;
      end
    end
    start = 1'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_done"}, {12'd0, done}, 13'd0);
      chk({tag, "_busy"}, {12'd0, busy}, 13'd0);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_result", result, 13'd0);
    chk("rst_busy", {12'd0, busy}, 13'd0);
    chk("rst_done", {12'd0, done}, 13'd0);
    chk("rst_flags", {10'd0, ovf, unf, dz}, 13'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic, normalise and sign
    do_op(13'h0800, 13'h0800, 13'h0800, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(13'h0C01, 13'h0C00, 13'h0801, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(13'h1800, 13'h0C00, 13'h1AAF, 1'b0, 1'b0, 1'b0, 1'b0);
    // Overflow, then a normal op clears it (q=182 -> mant B6, exp 0)
    do_op(13'h0FF7, 13'h0808, 13'h0FF7, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(13'h0A03, 13'h0E02, 13'h0B60, 1'b0, 1'b0, 1'b0, 1'b0);
    // Underflow, then negative/negative (q=384 -> mant C0, exp 1) clears it
    do_op(13'h0808, 13'h0FF7, 13'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(13'h1C01, 13'h1800, 13'h0C01, 1'b0, 1'b0, 1'b0, 1'b0);
    // Zero cases
    do_op(13'h0800, 13'h1000, 13'h1FF7, 1'b0, 1'b0, 1'b1, 1'b0);
    do_op(13'h0000, 13'h0800, 13'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stray starts while busy are ignored and not queued
    do_op(13'h0C01, 13'h0C00, 13'h0801, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_check(12, "noqueue");

    // start held high: done every 10 cycles
    @(negedge clk);
    one = 13'h0800; other = 13'h0800; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 30; c++) begin
      start = (c <= 20);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b_done_c%0d", c), {12'd0, done}, {12'd0, (c % 10 == 0)});
      chk($sformatf("b2b_busy_c%0d", c), {12'd0, busy}, {12'd0, (c % 10 != 0)});
    end
    start = 1'b0;
    last_res = 13'h0800;
    idle_check(3, "b2b_tail");

    // Reset mid-operation
    @(negedge clk);
    one = 13'h0C01; other = 13'h0C00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_busy", {12'd0, busy}, 13'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_result", result, 13'd0);
    chk("midrst_busy", {12'd0, busy}, 13'd0);
    chk("midrst_flags", {9'd0, done, ovf, unf, dz}, 13'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last_res = 13'd0;
    idle_check(12, "post_rst");
    do_op(13'h0800, 13'h0800, 13'h0800, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
